// File: rtl/gray_to_binary_sync_receiver.sv
// gray_to_binary_sync_receiver
//   Synchronises a gray-coded bus (counter / pointer) through a flop chain,
//   decodes it to binary and strobes Data_Valid_Out for one cycle whenever
//   the decoded value is reloaded.
//   Optional feature macro: GRAY_RX_STEP_CHECK_EN
//     defined   -> sticky Step_Error_Out flags any multi-bit gray step seen
//                  while tracking (cleared by Error_Clear_In or reset)
//     undefined -> no step checker, Step_Error_Out tied low,
//                  Error_Clear_In ignored
//   Legal parameter ranges: DATA_WIDTH 2..32, SYNC_STAGES 2..4.
module gray_to_binary_sync_receiver #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  Clock_In,
  input  logic                  Reset_n_In,
  input  logic                  Enable_In,
  input  logic [DATA_WIDTH-1:0] Gray_Data_In,
  input  logic                  Error_Clear_In,
  output logic [DATA_WIDTH-1:0] Binary_Data_Out,
  output logic                  Data_Valid_Out,
  output logic                  Step_Error_Out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    TRACK = 2'd2
  } state_t;

  state_t                state_reg;
  state_t                state_next;

  logic [DATA_WIDTH-1:0] sync_reg [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] gray_sync;
  logic [DATA_WIDTH-1:0] gray_dec;

  logic [DATA_WIDTH-1:0] bin_reg;
  logic [DATA_WIDTH-1:0] bin_next;
  logic [DATA_WIDTH-1:0] prev_reg;
  logic [DATA_WIDTH-1:0] prev_next;
  logic                  valid_reg;
  logic                  valid_next;
  logic                  gray_changed;

  // Synchroniser chain: shifts every cycle, independent of Enable_In, so the
  // last stage always reflects the input as of SYNC_STAGES edges ago.
  always_ff @(posedge Clock_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_reg[i] <= '0;
      end
    end else begin
      sync_reg[0] <= Gray_Data_In;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_reg[i] <= sync_reg[i-1];
      end
    end
  end

  assign gray_sync = sync_reg[SYNC_STAGES-1];

  // Gray decode: each binary bit is the XOR of all gray bits at or above it.
  // Written as independent reduction XORs so no bit depends on another
  // output bit (keeps the combinational graph flat).
  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_decode
      assign gray_dec[gi] = ^gray_sync[DATA_WIDTH-1:gi];
    end
  endgenerate

  assign gray_changed = (gray_sync != prev_reg);

`ifdef GRAY_RX_STEP_CHECK_EN
  logic [DATA_WIDTH-1:0] step_diff;
  logic                  multi_bit_step;
  logic                  step_set;
  logic                  err_reg;
  logic                  err_next;

  // More than one bit differs iff clearing the lowest set bit of the
  // difference still leaves something set; avoids a full popcount adder.
  assign step_diff      = gray_sync ^ prev_reg;
  assign multi_bit_step = ((step_diff & (step_diff - DATA_WIDTH'(1))) != '0);
`endif

  // FSM state register.
  always_ff @(posedge Clock_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and datapath-load decisions; defaults hold everything.
  always_comb begin
    state_next = state_reg;
    bin_next   = bin_reg;
    prev_next  = prev_reg;
    valid_next = 1'b0;
`ifdef GRAY_RX_STEP_CHECK_EN
    step_set   = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (Enable_In) begin
          state_next = PRIME;
        end
      end
      PRIME: begin
        // Unconditional reload: whatever happened while disabled is
        // accepted as the new reference without a step check.
        bin_next   = gray_dec;
        prev_next  = gray_sync;
        valid_next = 1'b1;
        state_next = Enable_In ? TRACK : IDLE;
      end
      TRACK: begin
        if (!Enable_In) begin
          state_next = IDLE;
        end else if (gray_changed) begin
          bin_next   = gray_dec;
          prev_next  = gray_sync;
          valid_next = 1'b1;
`ifdef GRAY_RX_STEP_CHECK_EN
          step_set   = multi_bit_step;
`endif
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output and reference registers.
  always_ff @(posedge Clock_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      bin_reg   <= '0;
      prev_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      bin_reg   <= bin_next;
      prev_reg  <= prev_next;
      valid_reg <= valid_next;
    end
  end

  assign Binary_Data_Out = bin_reg;
  assign Data_Valid_Out  = valid_reg;

`ifdef GRAY_RX_STEP_CHECK_EN
  // Sticky error: a new illegal step outranks a clear on the same edge so an
  // error is never lost.
  always_comb begin
    err_next = err_reg;
    if (step_set) begin
      err_next = 1'b1;
    end else if (Error_Clear_In) begin
      err_next = 1'b0;
    end
  end

  // Sticky error flag register.
  always_ff @(posedge Clock_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= err_next;
    end
  end

  assign Step_Error_Out = err_reg;
`else
  logic unused_error_clear;

  assign unused_error_clear = Error_Clear_In;
  assign Step_Error_Out     = 1'b0;
`endif

endmodule

// File: tb/tb_gray_to_binary_sync_receiver.sv
// Testbench for gray_to_binary_sync_receiver (DATA_WIDTH=16, SYNC_STAGES=2).
// Expected decoded values and their arrival cycles are queued when stimulus
// is driven; a negedge monitor pops one entry per Data_Valid_Out pulse.
// Step-error expectations follow GRAY_RX_STEP_CHECK_EN.
module tb_gray_to_binary_sync_receiver;

  localparam int W    = 16;
  localparam int SYNC = 2;
`ifdef GRAY_RX_STEP_CHECK_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] val;
    int           cyc;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         enable;
  logic [W-1:0] gray;
  logic         err_clear;
  logic [W-1:0] bin_out;
  logic         valid_out;
  logic         step_err;

  exp_t sb_q[$];
  int   cyc;
  int   check_count;
  int   error_count;
  logic exp_err;

  gray_to_binary_sync_receiver #(
    .DATA_WIDTH  (W),
    .SYNC_STAGES (SYNC)
  ) dut (
    .Clock_In        (clk),
    .Reset_n_In      (rst_n),
    .Enable_In       (enable),
    .Gray_Data_In    (gray),
    .Error_Clear_In  (err_clear),
    .Binary_Data_Out (bin_out),
    .Data_Valid_Out  (valid_out),
    .Step_Error_Out  (step_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_value(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [W-1:0] val, input int at_cyc);
    exp_t e;
    e.val = val;
    e.cyc = at_cyc;
    sb_q.push_back(e);
  endtask

  // Drive a new gray value while tracking; result expected SYNC+1 edges later.
  task automatic drive_gray(input logic [W-1:0] g, input logic [W-1:0] b);
    gray = g;
    push_exp(b, cyc + SYNC + 1);
    tick(4);
  endtask

  // Scoreboard monitor: one line per observed transaction.
  always @(negedge clk) begin
    exp_t e;
    if (valid_out === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_value("spurious_valid", valid_out, 1'b0);
      end else begin
        e = sb_q.pop_front();
        $display("txn cyc=%0d bin=%04h exp=%04h exp_cyc=%0d err=%0b",
                 cyc, bin_out, e.val, e.cyc, step_err);
        check_value("bin_value", bin_out, e.val);
        check_value("valid_cycle", cyc, e.cyc);
      end
    end else if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
      e = sb_q.pop_front();
      check_value("missed_valid", valid_out, 1'b1);
    end
  end

  initial begin
    cyc         = 0;
    check_count = 0;
    error_count = 0;
    exp_err     = 1'b0;
    rst_n       = 1'b0;
    enable      = 1'b0;
    err_clear   = 1'b0;
    gray        = 16'h1234;

    // 1: outputs held at zero throughout reset
    for (int i = 0; i < 2; i++) begin
      tick(1);
      check_value("rst_bin", bin_out, 16'h0000);
      check_value("rst_valid", valid_out, 1'b0);
      check_value("rst_err", step_err, 1'b0);
    end

    rst_n = 1'b1;
    gray  = 16'h0000;
    tick(3);
    check_value("idle_bin", bin_out, 16'h0000);
    check_value("idle_valid", valid_out, 1'b0);

    // Enable: PRIME load two edges later
    enable = 1'b1;
    push_exp(16'h0000, cyc + 2);
    tick(4);

    // 2: single-bit steps
    drive_gray(16'h0001, 16'h0001);
    drive_gray(16'h0003, 16'h0002);
    check_value("t2_err", step_err, exp_err);

    // 3: jump to 8000h (3-bit step), clear, then legal wrap to 0000h
    drive_gray(16'h8000, 16'hFFFF);
    exp_err = STEP_EN;
    check_value("t3_err_set", step_err, exp_err);
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    exp_err   = 1'b0;
    check_value("t3_err_clr", step_err, exp_err);
    drive_gray(16'h0000, 16'h0000);
    check_value("t3_wrap_err", step_err, exp_err);

    // 4: multi-bit step sets sticky error
    drive_gray(16'h0001, 16'h0001);
    drive_gray(16'h0007, 16'h0005);
    exp_err = STEP_EN;
    check_value("t4_err_set", step_err, exp_err);
    tick(2);
    check_value("t4_err_sticky", step_err, exp_err);
    // Clear coincides with another 2-bit step: set wins
    gray = 16'h0001;
    push_exp(16'h0001, cyc + SYNC + 1);
    tick(2);
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    check_value("t4_set_wins", step_err, exp_err);
    tick(1);
    // Clear alone
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    exp_err   = 1'b0;
    check_value("t4_clear", step_err, exp_err);
    drive_gray(16'h0003, 16'h0002);

    // 5: disabled period, then PRIME reload without step check
    enable = 1'b0;
    gray   = 16'h00F0;
    tick(6);
    check_value("t5_hold_bin", bin_out, 16'h0002);
    check_value("t5_hold_err", step_err, exp_err);
    enable = 1'b1;
    push_exp(16'h00A0, cyc + 2);
    tick(4);
    check_value("t5_prime_bin", bin_out, 16'h00A0);
    check_value("t5_prime_err", step_err, exp_err);

    // 6: asynchronous reset mid-stream
    #2;
    rst_n  = 1'b0;
    enable = 1'b0;
    #1;
    check_value("t6_async_bin", bin_out, 16'h0000);
    check_value("t6_async_valid", valid_out, 1'b0);
    check_value("t6_async_err", step_err, 1'b0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    check_value("t6_idle_bin", bin_out, 16'h0000);
    enable = 1'b1;
    push_exp(16'h00A0, cyc + 2);
    tick(4);
    check_value("t6_reload_bin", bin_out, 16'h00A0);
    check_value("t6_reload_err", step_err, 1'b0);

    tick(5);
    check_value("sb_drain", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
